// File: rtl/baud.sv
// Baud divider: counts 0..DIV-1, pulses tick_o on the terminal count.
// restart_i forces the count back to zero so a new frame starts on a clean bit boundary.
module baud #(
  parameter int DIV = 1250
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/transmit.sv
// UART transmitter, 8 data bits, 1 or 2 stop bits, one-entry holding register.
// States: IDLE line high | START start bit | DATA shifting dat[0..7] | STOP stop bit(s)
module transmit #(
  parameter int BAUD = 9600,
  parameter int FREQ = 12000000,
  parameter int STOP = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic [7:0] dat,
  output logic       rdy,
  output logic       txd
);

  localparam int DIV = FREQ / BAUD;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t     state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic [2:0] bit_q, bit_d;
  logic       rdy_q, rdy_d;
  logic       txd_q, txd_d;
  logic       xfer, load_dat, restart, tick;

  baud #(.DIV(DIV)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .restart_i(restart),
    .tick_o   (tick)
  );

  assign xfer = stb && rdy_q;
  assign rdy  = rdy_q;
  assign txd  = txd_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_d       = bit_q;
    load_dat    = 1'b0;
    restart     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          shift_d  = dat;
          load_dat = 1'b1;
          restart  = 1'b1;
          bit_d    = '0;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          if (bit_q == 3'(STOP - 1)) begin
            bit_d = '0;
            // Queued byte takes priority; otherwise a same-cycle transfer bypasses the holding register.
            if (hold_full_q) begin
              shift_d     = hold_q;
              hold_full_d = 1'b0;
              restart     = 1'b1;
              state_d     = S_START;
            end else if (xfer) begin
              shift_d  = dat;
              load_dat = 1'b1;
              restart  = 1'b1;
              state_d  = S_START;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (xfer && !load_dat) begin
      hold_d      = dat;
      hold_full_d = 1'b1;
    end

    rdy_d = !hold_full_d;

    case (state_d)
      S_START: txd_d = 1'b0;
      S_DATA:  txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_q       <= '0;
      rdy_q       <= 1'b1;
      txd_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_q       <= bit_d;
      rdy_q       <= rdy_d;
      txd_q       <= txd_d;
    end
  end

endmodule

// File: tb/tb_transmit.sv
// Directed bench for transmit with FREQ=8, BAUD=1 (8 clocks per bit); a UART line model
// decodes frames and checks them against a queue of bytes pushed at each accepted transfer.
module tb_transmit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       stb = 1'b0, stb2 = 1'b0;
  logic [7:0] dat = 8'h00, dat2 = 8'h00;
  logic       rdy, txd, rdy2, txd2;

  always #5 clk = ~clk;

  transmit #(.BAUD(1), .FREQ(8), .STOP(1)) dut (
    .clk(clk), .rst(rst), .stb(stb), .dat(dat), .rdy(rdy), .txd(txd)
  );

  transmit #(.BAUD(1), .FREQ(8), .STOP(2)) dut2 (
    .clk(clk), .rst(rst), .stb(stb2), .dat(dat2), .rdy(rdy2), .txd(txd2)
  );

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  int         rx_cnt = 0;
  int         rdy_rises = 0;
  logic       rdy_prev = 1'b1;
  logic [7:0] exp_q[$];
  int         start_q[$];
  logic       mon_s[0:79];
  logic       s2[0:199];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rdy === 1'b1 && rdy_prev === 1'b0) rdy_rises <= rdy_rises + 1;
    rdy_prev <= rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Line model: a start bit seen at a falling-edge sample begins an 80-sample frame.
  initial begin : uart_model
    logic [7:0] b;
    logic       ok, shape;
    logic [8:0] e;
    int         t0;
    forever begin
      @(negedge clk);
      if (!rst && txd === 1'b0) begin
        t0 = cyc;
        ok = 1'b1;
        mon_s[0] = 1'b0;
        for (int i = 1; i < 80; i++) begin
          @(negedge clk);
          if (rst) begin
            ok = 1'b0;
            break;
          end
          mon_s[i] = txd;
        end
        if (ok) begin
          shape = 1'b1;
          for (int i = 0; i < 8; i++) if (mon_s[i] !== 1'b0) shape = 1'b0;
          for (int j = 0; j < 8; j++) begin
            b[j] = mon_s[12 + 8 * j];
            for (int k = 0; k < 8; k++) if (mon_s[8 + 8 * j + k] !== b[j]) shape = 1'b0;
          end
          for (int i = 72; i < 80; i++) if (mon_s[i] !== 1'b1) shape = 1'b0;
          check("frame_shape", 32'(shape), 32'd1);
          e = (exp_q.size() != 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
          check("rx_byte", {24'h0, b}, {23'h0, e});
          rx_cnt++;
          start_q.push_back(t0);
        end
      end
    end
  end

  // Called at a falling edge; returns with stb still high at the falling edge after the transfer.
  task automatic send(input logic [7:0] b, output int k);
    int w;
    w = 0;
    stb = 1'b1;
    dat = b;
    while (rdy !== 1'b1 && w < 400) begin
      @(negedge clk);
      w++;
    end
    check("send_accepted", 32'(rdy), 32'd1);
    if (rdy === 1'b1) exp_q.push_back(b);
    k = cyc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_rx(input int n, input int maxc);
    int w;
    w = 0;
    while (rx_cnt < n && w < maxc) begin
      @(negedge clk);
      w++;
    end
    check("rx_count", 32'(rx_cnt), 32'(n));
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k1, k2, bad, r0, n0, w, z1, o1, z2, o2;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_txd", 32'(txd), 32'd1);
    check("reset_rdy", 32'(rdy), 32'd1);
    rst = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || rdy !== 1'b1) bad++;
    end
    check("idle_100", 32'(bad), 32'd0);

    // Single frame 0xA5
    start_q.delete();
    send(8'hA5, k1);
    stb = 1'b0;
    wait_rx(1, 200);
    check("a5_latency", 32'(start_q.size() > 0 ? start_q[0] - k1 : -1), 32'd1);
    check("a5_line_idle", 32'(txd), 32'd1);

    // 0x55 then 0x0F back to back through the holding register
    start_q.delete();
    n0 = rx_cnt;
    send(8'h55, k1);
    send(8'h0F, k2);
    stb = 1'b0;
    check("hold_rdy_low", 32'(rdy), 32'd0);
    w = 0;
    while (rdy !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    r0 = cyc;
    check("rdy_rise_cycle", 32'(r0 - k1), 32'd81);
    wait_rx(n0 + 2, 300);
    check("b2b_gap", 32'(start_q.size() > 1 ? start_q[1] - start_q[0] : -1), 32'd80);

    // Continuous stream 0x00..0x09
    repeat (5) @(negedge clk);
    start_q.delete();
    n0 = rx_cnt;
    r0 = rdy_rises;
    for (int i = 0; i < 10; i++) send(8'(i), k2);
    stb = 1'b0;
    wait_rx(n0 + 10, 1200);
    bad = 0;
    for (int i = 1; i < start_q.size(); i++) if (start_q[i] - start_q[i-1] != 80) bad++;
    check("stream_gaps", 32'(bad), 32'd0);
    check("stream_frames", 32'(start_q.size()), 32'd10);
    repeat (3) @(negedge clk);
    check("stream_rdy_pulses", 32'(rdy_rises - r0), 32'd9);
    check("stream_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset mid-frame with a byte queued
    n0 = rx_cnt;
    send(8'hFF, k1);
    send(8'h33, k2);
    stb = 1'b0;
    w = 0;
    while (cyc < k1 + 30 && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("pre_reset_rdy", 32'(rdy), 32'd0);
    rst = 1'b1;
    #1;
    check("rst_async_txd", 32'(txd), 32'd1);
    check("rst_async_rdy", 32'(rdy), 32'd1);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    check("post_reset_idle", 32'(bad), 32'd0);
    check("queued_discarded", 32'(rx_cnt), 32'(n0));
    send(8'hC3, k1);
    stb = 1'b0;
    wait_rx(n0 + 1, 200);

    // STOP=2 instance: two back-to-back 0x00 frames expose the 16-cycle stop level
    stb2 = 1'b1;
    dat2 = 8'h00;
    k1 = cyc;
    @(posedge clk);
    @(negedge clk);
    s2[0] = txd2;
    @(posedge clk);
    @(negedge clk);
    stb2 = 1'b0;
    s2[1] = txd2;
    for (int i = 2; i < 200; i++) begin
      @(negedge clk);
      s2[i] = txd2;
    end
    z1 = 0; o1 = 0; z2 = 0; o2 = 0;
    for (int i = 0; i < 72; i++)    if (s2[i] === 1'b0) z1++;
    for (int i = 72; i < 88; i++)   if (s2[i] === 1'b1) o1++;
    for (int i = 88; i < 160; i++)  if (s2[i] === 1'b0) z2++;
    for (int i = 160; i < 200; i++) if (s2[i] === 1'b1) o2++;
    check("stop2_first_low", 32'(z1), 32'd72);
    check("stop2_stop_len", 32'(o1), 32'd16);
    check("stop2_next_start", 32'(s2[88]), 32'd0);
    check("stop2_second_low", 32'(z2), 32'd72);
    check("stop2_tail_high", 32'(o2), 32'd40);
    check("stop2_rdy_idle", 32'(rdy2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
